// File: rtl/cam_ram_part_pkg.sv
// Shared types and init-pattern helper for the partition-gated CAM/RAM.
package cam_ram_part_pkg;

    typedef enum logic [1:0] {PS_OFF, PS_INIT, PS_READY} partState_t;

    localparam int RAM_RESET_ZERO = 0;
    localparam int RAM_RESET_SEQ  = 1;

    function automatic int initValue(input int resetVal, input int seqStart, input int globalIdx);
        return (resetVal == RAM_RESET_SEQ) ? seqStart + globalIdx : 0;
    endfunction

endpackage

// File: rtl/cam_ram_part_bank.sv
// One partition: storage, valid bits, OFF/INIT/READY FSM and sequential init counter.
module cam_ram_part_bank
    import cam_ram_part_pkg::*;
#(
    parameter int   PDEPTH           = 16,
    parameter int   PINDEX           = 4,
    parameter int   WIDTH            = 8,
    parameter int   NUM_WR_PORTS     = 4,
    parameter int   NUM_CAM_RD_PORTS = 4,
    parameter int   FUNCTION         = 0,
    parameter int   RESET_VAL        = RAM_RESET_ZERO,
    parameter int   SEQ_START        = 0,
    parameter logic INIT_VALID       = 1'b0,
    parameter int   BASE             = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               gate,
    input  logic [NUM_WR_PORTS-1:0]            wrEn,
    input  logic [NUM_WR_PORTS*PINDEX-1:0]     addrWr,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]      dataWr,
    input  logic [PDEPTH-1:0]                  clrVect,
    input  logic [NUM_CAM_RD_PORTS*WIDTH-1:0]  tag,
    output logic [NUM_CAM_RD_PORTS*PDEPTH-1:0] vect,
    output logic [WIDTH-1:0]                   entries [PDEPTH],
    output partState_t                         state
);

    logic [WIDTH-1:0]  mem [PDEPTH];
    logic [PDEPTH-1:0] valid;
    logic [PINDEX-1:0] cnt;
    logic [WIDTH-1:0]  initData;
    logic              hit;

    assign initData = WIDTH'(initValue(RESET_VAL, SEQ_START, BASE + int'(cnt)));
    assign entries  = mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= gate ? PS_OFF : PS_INIT;
            cnt   <= '0;
            valid <= '0;
        end else begin
            case (state)
                PS_OFF: begin
                    if (!gate) begin
                        state <= PS_INIT;
                        cnt   <= '0;
                    end
                end
                PS_INIT: begin
                    if (gate) begin
                        state <= PS_OFF;
                        valid <= '0;
                    end else begin
                        valid[cnt] <= INIT_VALID;
                        cnt        <= cnt + 1'b1;
                        if (cnt == PINDEX'(PDEPTH - 1))
                            state <= PS_READY;
                    end
                end
                PS_READY: begin
                    if (gate) begin
                        state <= PS_OFF;
                        valid <= '0;
                    end else begin
                        // Clears first so a same-cycle write to the entry leaves it valid.
                        valid <= valid & ~clrVect;
                        for (int w = 0; w < NUM_WR_PORTS; w++)
                            if (wrEn[w]) valid[addrWr[w*PINDEX +: PINDEX]] <= 1'b1;
                    end
                end
                default: state <= PS_OFF;
            endcase
        end
    end

    // Ascending port order makes the highest-numbered port win a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == PS_INIT) begin
                mem[cnt] <= initData;
            end else if (state == PS_READY) begin
                for (int w = 0; w < NUM_WR_PORTS; w++)
                    if (wrEn[w]) mem[addrWr[w*PINDEX +: PINDEX]] <= dataWr[w*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        vect = '0;
        hit  = 1'b0;
        for (int c = 0; c < NUM_CAM_RD_PORTS; c++) begin
            for (int i = 0; i < PDEPTH; i++) begin
                hit = (FUNCTION != 0) ? (mem[i] > tag[c*WIDTH +: WIDTH])
                                      : (mem[i] == tag[c*WIDTH +: WIDTH]);
                vect[c*PDEPTH + i] = valid[i] & hit & (state == PS_READY);
            end
        end
    end

endmodule

// File: rtl/cam_ram_part_gated.sv
// Partitioned CAM/RAM with run-time partition gating; routes ports to banks and muxes reads.
module cam_ram_part_gated
    import cam_ram_part_pkg::*;
#(
    parameter int   DEPTH            = 64,
    parameter int   INDEX            = 6,
    parameter int   WIDTH            = 8,
    parameter int   FUNCTION         = 0,
    parameter int   NUM_WR_PORTS     = 4,
    parameter int   NUM_CAM_RD_PORTS = 4,
    parameter int   NUM_RAM_RD_PORTS = 4,
    parameter int   NUM_PARTS        = 4,
    parameter int   NUM_PARTS_LOG    = 2,
    parameter int   RESET_VAL        = RAM_RESET_ZERO,
    parameter int   SEQ_START        = 0,
    parameter logic INIT_VALID       = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PARTS-1:0]              partGate_i,
    output logic [NUM_PARTS-1:0]              partReady_o,
    output logic                              ramReady_o,
    input  logic [NUM_CAM_RD_PORTS*WIDTH-1:0] tag_i,
    output logic [NUM_CAM_RD_PORTS*DEPTH-1:0] vect_o,
    input  logic [NUM_RAM_RD_PORTS*INDEX-1:0] addr_i,
    output logic [NUM_RAM_RD_PORTS*WIDTH-1:0] data_o,
    input  logic [NUM_WR_PORTS*INDEX-1:0]     addrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]     dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]           wrEn_i,
    input  logic [DEPTH-1:0]                  clrVect_i,
    output logic [NUM_WR_PORTS-1:0]           wrDropped_o
);

    localparam int PDEPTH = DEPTH / NUM_PARTS;
    localparam int PINDEX = INDEX - NUM_PARTS_LOG;
    localparam int PSEL   = (NUM_PARTS_LOG == 0) ? 1 : NUM_PARTS_LOG;

    // Shifting out the local bits yields 0 when there is a single partition.
    function automatic logic [PSEL-1:0] partOf(input logic [INDEX-1:0] a);
        return PSEL'(a >> PINDEX);
    endfunction

    logic [NUM_WR_PORTS*PINDEX-1:0]     localAddrWr;
    logic [NUM_WR_PORTS-1:0]            bankWrEn   [NUM_PARTS];
    logic [NUM_CAM_RD_PORTS*PDEPTH-1:0] bankVect   [NUM_PARTS];
    logic [WIDTH-1:0]                   bankEntries[NUM_PARTS][PDEPTH];
    partState_t                         partState  [NUM_PARTS];

    always_comb begin
        localAddrWr = '0;
        for (int w = 0; w < NUM_WR_PORTS; w++)
            localAddrWr[w*PINDEX +: PINDEX] = addrWr_i[w*INDEX +: PINDEX];
        for (int p = 0; p < NUM_PARTS; p++) begin
            bankWrEn[p] = '0;
            for (int w = 0; w < NUM_WR_PORTS; w++)
                bankWrEn[p][w] = wrEn_i[w] && (partOf(addrWr_i[w*INDEX +: INDEX]) == PSEL'(p));
        end
    end

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_bank
        cam_ram_part_bank #(
            .PDEPTH(PDEPTH), .PINDEX(PINDEX), .WIDTH(WIDTH),
            .NUM_WR_PORTS(NUM_WR_PORTS), .NUM_CAM_RD_PORTS(NUM_CAM_RD_PORTS),
            .FUNCTION(FUNCTION), .RESET_VAL(RESET_VAL), .SEQ_START(SEQ_START),
            .INIT_VALID(INIT_VALID), .BASE(p * PDEPTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .gate    (partGate_i[p]),
            .wrEn    (bankWrEn[p]),
            .addrWr  (localAddrWr),
            .dataWr  (dataWr_i),
            .clrVect (clrVect_i[p*PDEPTH +: PDEPTH]),
            .tag     (tag_i),
            .vect    (bankVect[p]),
            .entries (bankEntries[p]),
            .state   (partState[p])
        );
        assign partReady_o[p] = (partState[p] == PS_READY);
    end

    always_comb begin
        vect_o = '0;
        for (int c = 0; c < NUM_CAM_RD_PORTS; c++)
            for (int p = 0; p < NUM_PARTS; p++)
                vect_o[c*DEPTH + p*PDEPTH +: PDEPTH] = bankVect[p][c*PDEPTH +: PDEPTH];
    end

    // A partition that is gated never holds the ready summary low.
    assign ramReady_o = &(partReady_o | partGate_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_o      <= '0;
            wrDropped_o <= '0;
        end else begin
            for (int r = 0; r < NUM_RAM_RD_PORTS; r++)
                data_o[r*WIDTH +: WIDTH] <= partReady_o[partOf(addr_i[r*INDEX +: INDEX])]
                    ? bankEntries[partOf(addr_i[r*INDEX +: INDEX])][addr_i[r*INDEX +: PINDEX]]
                    : '0;
            for (int w = 0; w < NUM_WR_PORTS; w++)
                wrDropped_o[w] <= wrEn_i[w] && !partReady_o[partOf(addrWr_i[w*INDEX +: INDEX])];
        end
    end

endmodule

// File: tb/tb_cam_ram_part_gated.sv
// Directed bench: one equality-CAM and one greater-than-CAM instance driven by shared inputs.
module tb_cam_ram_part_gated;
    import cam_ram_part_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  partGate;
    logic [31:0] tag;
    logic [23:0] addr;
    logic [23:0] addrWr;
    logic [31:0] dataWr;
    logic [3:0]  wrEn;
    logic [63:0] clrVect;

    logic [3:0]   partReady0, partReady1;
    logic         ramReady0, ramReady1;
    logic [255:0] vect0, vect1;
    logic [31:0]  data0, data1;
    logic [3:0]   wrDropped0, wrDropped1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cam_ram_part_gated #(.FUNCTION(0), .RESET_VAL(RAM_RESET_SEQ), .SEQ_START(0), .INIT_VALID(1'b1)) dut0 (
        .clk(clk), .reset(reset), .partGate_i(partGate), .partReady_o(partReady0),
        .ramReady_o(ramReady0), .tag_i(tag), .vect_o(vect0), .addr_i(addr), .data_o(data0),
        .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn), .clrVect_i(clrVect),
        .wrDropped_o(wrDropped0)
    );

    cam_ram_part_gated #(.FUNCTION(1), .RESET_VAL(RAM_RESET_SEQ), .SEQ_START(0), .INIT_VALID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .partGate_i(partGate), .partReady_o(partReady1),
        .ramReady_o(ramReady1), .tag_i(tag), .vect_o(vect1), .addr_i(addr), .data_o(data1),
        .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn), .clrVect_i(clrVect),
        .wrDropped_o(wrDropped1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int w, input logic [5:0] a, input logic [7:0] d);
        wrEn[w]             = 1'b1;
        addrWr[w*6 +: 6]    = a;
        dataWr[w*8 +: 8]    = d;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1; partGate = 4'h0; tag = '0; addr = '0; addrWr = '0;
        dataWr = '0; wrEn = '0; clrVect = '0;
        tick();
        checks++; if (partReady0 !== 4'h0) $display("FAIL reset_partReady: got %h expected 0", partReady0); else passes++;
        checks++; if (ramReady0 !== 1'b0) $display("FAIL reset_ramReady: got %b expected 0", ramReady0); else passes++;
        checks++; if (data0 !== 32'h0) $display("FAIL reset_data: got %h expected 0", data0); else passes++;
        checks++; if (wrDropped0 !== 4'h0) $display("FAIL reset_wrDropped: got %h expected 0", wrDropped0); else passes++;
        checks++; if (vect0 !== 256'h0) $display("FAIL reset_vect: got %h expected 0", vect0); else passes++;
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (partReady0 !== 4'h0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL init_early_ready: partReady rose before edge 16, now %h", partReady0); else passes++;
        tick();
        checks++; if (partReady0 !== 4'hF) $display("FAIL init_ready: got %h expected f", partReady0); else passes++;
        checks++; if (ramReady0 !== 1'b1) $display("FAIL init_ramReady: got %b expected 1", ramReady0); else passes++;
    endtask

    task automatic test_read_cam();
        addr = {6'd63, 6'd16, 6'd15, 6'd37};
        tag  = {8'd0, 8'd0, 8'd0, 8'd37};
        #1;
        checks++; if (vect0[63:0] !== 64'h0000_0020_0000_0000) $display("FAIL cam_eq_37: got %h expected 0000002000000000", vect0[63:0]); else passes++;
        checks++; if (vect0[127:64] !== 64'h1) $display("FAIL cam_eq_0: got %h expected 1", vect0[127:64]); else passes++;
        checks++; if (vect1[63:0] !== 64'hFFFF_FFC0_0000_0000) $display("FAIL cam_gt_37: got %h expected ffffffc000000000", vect1[63:0]); else passes++;
        tick();
        checks++; if (data0 !== 32'h3F10_0F25) $display("FAIL read_seq: got %h expected 3f100f25", data0); else passes++;
    endtask

    task automatic test_collision();
        set_wr(0, 6'd5, 8'h11);
        set_wr(3, 6'd5, 8'h22);
        set_wr(1, 6'd6, 8'h66);
        addr[5:0] = 6'd6;
        tick();
        wrEn = '0;
        checks++; if (wrDropped0 !== 4'h0) $display("FAIL collide_dropped: got %h expected 0", wrDropped0); else passes++;
        checks++; if (data0[7:0] !== 8'h06) $display("FAIL read_first: got %h expected 06", data0[7:0]); else passes++;
        addr[5:0] = 6'd5; addr[11:6] = 6'd6;
        tag[7:0]  = 8'h22;
        tick();
        checks++; if (data0[15:0] !== 16'h6622) $display("FAIL collide_data: got %h expected 6622", data0[15:0]); else passes++;
        checks++; if (vect0[63:0] !== 64'h0000_0004_0000_0020) $display("FAIL collide_cam: got %h expected 0000000400000020", vect0[63:0]); else passes++;
    endtask

    task automatic test_gate();
        set_wr(2, 6'd40, 8'hAB);
        tick();
        wrEn = '0;
        checks++; if (wrDropped0 !== 4'h0) $display("FAIL live_write_dropped: got %h expected 0", wrDropped0); else passes++;
        partGate = 4'b0100;
        tick();
        checks++; if (partReady0 !== 4'hB) $display("FAIL gate_ready: got %h expected b", partReady0); else passes++;
        checks++; if (ramReady0 !== 1'b1) $display("FAIL gate_ramReady: got %b expected 1", ramReady0); else passes++;
        set_wr(1, 6'd40, 8'h99);
        tag[7:0] = 8'hAB;
        addr[5:0] = 6'd40;
        tick();
        wrEn = '0;
        checks++; if (wrDropped0 !== 4'b0010) $display("FAIL gate_dropped: got %h expected 2", wrDropped0); else passes++;
        checks++; if (data0[7:0] !== 8'h00) $display("FAIL gate_data: got %h expected 00", data0[7:0]); else passes++;
        checks++; if (vect0[63:0] !== 64'h0) $display("FAIL gate_vect: got %h expected 0", vect0[63:0]); else passes++;
    endtask

    task automatic test_ungate();
        bit bad;
        partGate = 4'b0000;
        tick();
        checks++; if (partReady0 !== 4'hB) $display("FAIL ungate_start: got %h expected b", partReady0); else passes++;
        checks++; if (ramReady0 !== 1'b0) $display("FAIL ungate_ramReady: got %b expected 0", ramReady0); else passes++;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (partReady0[2] !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL ungate_early: partReady[2] rose early, now %h", partReady0); else passes++;
        tick();
        checks++; if (partReady0 !== 4'hF) $display("FAIL ungate_ready: got %h expected f", partReady0); else passes++;
        tag[7:0] = 8'd40;
        tick();
        checks++; if (data0[7:0] !== 8'd40) $display("FAIL ungate_reinit: got %h expected 28", data0[7:0]); else passes++;
        checks++; if (vect0[63:0] !== 64'h0000_0100_0000_0000) $display("FAIL ungate_cam: got %h expected 0000010000000000", vect0[63:0]); else passes++;
    endtask

    task automatic test_function1();
        set_wr(0, 6'd5, 8'd5);
        set_wr(1, 6'd6, 8'd6);
        tick();
        wrEn = '0;
        tag[7:0] = 8'd10;
        #1;
        checks++; if (vect1[63:0] !== 64'hFFFF_FFFF_FFFF_F800) $display("FAIL gt_10: got %h expected fffffffffffff800", vect1[63:0]); else passes++;
        clrVect = 64'h0000_0000_0000_3000;
        set_wr(0, 6'd13, 8'd13);
        tick();
        clrVect = '0; wrEn = '0;
        checks++; if (vect1[15:0] !== 16'hE800) $display("FAIL clr_vs_write: got %h expected e800", vect1[15:0]); else passes++;
    endtask

    task automatic test_reset_mid_init();
        bit bad;
        set_wr(0, 6'd20, 8'hEE);
        tick();
        wrEn = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (partReady0 !== 4'h0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL restart_early: partReady rose early, now %h", partReady0); else passes++;
        tick();
        checks++; if (partReady0 !== 4'hF) $display("FAIL restart_ready: got %h expected f", partReady0); else passes++;
        addr[5:0] = 6'd20;
        tick();
        checks++; if (data0[7:0] !== 8'd20) $display("FAIL restart_data: got %h expected 14", data0[7:0]); else passes++;
        checks++; if (vect1[63:0] !== 64'hFFFF_FFFF_FFFF_F800) $display("FAIL restart_gt_10: got %h expected fffffffffffff800", vect1[63:0]); else passes++;
    endtask

    task automatic test_all_gated();
        partGate = 4'hF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (ramReady0 !== 1'b1) $display("FAIL all_gated_ramReady: got %b expected 1", ramReady0); else passes++;
        checks++; if (partReady0 !== 4'h0) $display("FAIL all_gated_ready: got %h expected 0", partReady0); else passes++;
        set_wr(3, 6'd0, 8'h55);
        tick();
        wrEn = '0;
        checks++; if (wrDropped0 !== 4'b1000) $display("FAIL all_gated_dropped: got %h expected 8", wrDropped0); else passes++;
    endtask

    initial begin
        test_reset();
        test_read_cam();
        test_collision();
        test_gate();
        test_ungate();
        test_function1();
        test_reset_mid_init();
        test_all_gated();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cam_ram_part_gated.md
# cam_ram_part_gated

Partitioned CAM/RAM with per-entry valid bits, run-time partition power gating, and a per-partition sequential initialisation engine. Replaces the static partitioned CAM in issue-queue and free-list style structures where partitions are gated and re-enabled while the core runs. A re-enabled partition must be re-initialised before use. RAM reads are registered; CAM match is combinational on current contents.

## Interface
- DEPTH, 64: total entries; power of two, multiple of NUM_PARTS.
- INDEX, 6: log2(DEPTH).
- WIDTH, 8: entry data width.
- FUNCTION, 0: 0 = match on tag == entry; 1 = match on entry > tag (unsigned).
- NUM_WR_PORTS, 4: write ports.
- NUM_CAM_RD_PORTS, 4: CAM search ports.
- NUM_RAM_RD_PORTS, 4: indexed read ports.
- NUM_PARTS, 4: partitions; power of two, ≥1.
- NUM_PARTS_LOG, 2: log2(NUM_PARTS); 0 allowed when NUM_PARTS = 1.
- RESET_VAL, `RAM_RESET_ZERO: init value; ZERO writes 0, SEQ writes SEQ_START + global index.
- SEQ_START, 0: base of the SEQ pattern.
- INIT_VALID, 0: valid bit written during init.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  synchronous, active-high.
- partGate_i  in  NUM_PARTS  1 = partition requested off.
- partReady_o  out  NUM_PARTS  partition in READY.
- ramReady_o  out  1  every ungated partition READY.
- tag_i  in  NUM_CAM_RD_PORTS×WIDTH  search tags.
- vect_o  out  NUM_CAM_RD_PORTS×DEPTH  match vector; bit i = entry i.
- addr_i  in  NUM_RAM_RD_PORTS×INDEX  read address.
- data_o  out  NUM_RAM_RD_PORTS×WIDTH  registered read data.
- addrWr_i  in  NUM_WR_PORTS×INDEX  write address.
- dataWr_i  in  NUM_WR_PORTS×WIDTH  write data; sets valid.
- wrEn_i  in  NUM_WR_PORTS  write enable.
- clrVect_i  in  DEPTH  clear valid bit of entry i.
- wrDropped_o  out  NUM_WR_PORTS  registered; write was discarded.

## Operation
- Partition p = addr[INDEX-1 -: NUM_PARTS_LOG]; local index = low INDEX-NUM_PARTS_LOG bits; PDEPTH = DEPTH/NUM_PARTS.
- Per-partition FSM with states OFF, INIT, READY:
  - reset: go to INIT, or to OFF if partGate_i[p]=1; init counter = 0.
  - INIT: write entry counter with the init value and INIT_VALID, then counter++. After local index PDEPTH-1 → READY. partGate_i[p]=1 aborts to OFF.
  - READY: partGate_i[p]=1 → OFF.
  - OFF: all valid bits cleared on entry. partGate_i[p]=0 → INIT, counter=0.
- Writes apply only in READY; otherwise the write is dropped and wrDropped_o[w]=1 the next cycle.
- Same-address collision: highest-numbered write port wins; losers are not flagged dropped.
- clrVect_i takes effect in READY only. Same-cycle write and clear of one entry: the write wins (valid=1).
- vect_o bit = valid & match & (state==READY).
- data_o = entry data if READY, else 0. Stale data in invalid entries is still returned in READY.

## Timing
- Reset values: vect_o 0; data_o 0; wrDropped_o 0; partReady_o 0; ramReady_o 0 unless all partitions are gated. ramReady_o is 1 when every partition is gated, since no ungated partition remains.
- Init: reset high at edge k → entry j written at edge k+1+j. partReady_o rises after edge k+PDEPTH.
- Ungate follows the same timing, counted from the edge that samples partGate_i=0.
- Gate: partReady_o and vect_o bits of p drop the cycle after partGate_i is sampled 1.
- Write at edge e: visible on vect_o and to reads issued from cycle e on.
- data_o: one-cycle latency. Read and write to the same address in one cycle returns old data (read-first).
- Reset mid-INIT restarts the counter at 0.

## Structure
- Package cam_ram_part_pkg: partState_t enum {PS_OFF, PS_INIT, PS_READY}, and function initValue(globalIdx) for the ZERO and SEQ patterns.
- Sub-module cam_ram_part_bank: one partition's storage, valid bits, FSM and init counter, instantiated NUM_PARTS times.
- Top level handles:
  - address split;
  - write-enable decode;
  - collision priority;
  - vect_o concatenation;
  - registered read mux;
  - ramReady_o reduction.

## Test plan
- Reset, DEPTH=64, NUM_PARTS=4, RESET_VAL=SEQ, SEQ_START=0, INIT_VALID=1 → partReady_o=4'hF after edge 16. Read addr 37 returns 37 one cycle later. CAM tag 37 (FUNCTION=0) sets only vect_o bit 37.
- Write port0 and port3 both to addr 5, data 0x11 and 0x22 → read returns 0x22. wrDropped_o = 0.
- Gate partition 2, write addr 40 → wrDropped_o[w]=1. vect_o bits 32–47 = 0; data_o = 0.
- Ungate partition 2 → partReady_o[2] rises 16 cycles later. Entry 40 is reinitialised to 40.
- FUNCTION=1, entries 0..15 = index, tag 10 → vect_o bits 11–15 set. clrVect_i bit 12 → bit 12 clears the next cycle.
- Reset asserted at init cycle 7 → counter restarts; ready 16 cycles after reset deasserts.
